// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display blocks.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost byte.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  // Table lookup; dp (bit 7) is off in every entry.
  always_comb begin
    seg = SEG_TABLE[hex];
  end

endmodule

// File: rtl/seg7_scan_arbiter.sv
// 8-digit display scanner with a two-client round-robin arbiter and a frame buffer that
// only reloads at frame boundaries, so a frame is never drawn from mixed client data.
module seg7_scan_arbiter
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BLANK_CYC   = 8,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [31:0]           data0_i,
  input  logic [31:0]           data1_i,
  output logic [1:0]            ack_o,
  output logic                  owner_o,
  output logic                  frame_start_o,
  output logic [NUM_DIGITS-1:0] sel_o,
  output logic [7:0]            seg_o
);

  localparam int unsigned DIV    = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_FRAMES);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [31:0]           frame_buf_q, frame_buf_d;
  logic                  owner_q, owner_d;
  logic [1:0]            ack_q, ack_d;
  logic                  fs_q, fs_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic       tick;
  logic       boundary;
  logic       other;
  logic [3:0] nibble;
  logic [7:0] digit_seg;

  assign tick     = (cnt_q == CNT_MAX);
  assign boundary = tick && (idx_q == 3'd7);
  assign other    = ~owner_q;
  // Digit 0 is the most significant nibble.
  assign nibble   = frame_buf_q[{~idx_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .hex (nibble),
    .seg (digit_seg)
  );

  // Prescaler, digit index and boundary-only arbitration.
  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    idx_d       = tick ? idx_q + 3'd1 : idx_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    frame_buf_d = frame_buf_q;
    ack_d       = 2'b00;
    fs_d        = boundary;
    if (boundary) begin
      if (req_i[other] && (!req_i[owner_q] || hold_q >= HOLD_MAX)) begin
        owner_d       = other;
        hold_d        = '0;
        frame_buf_d   = other ? data1_i : data0_i;
        ack_d[other]  = 1'b1;
      end else if (req_i[owner_q]) begin
        frame_buf_d    = owner_q ? data1_i : data0_i;
        ack_d[owner_q] = 1'b1;
        if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
    end
  end

  // Pin values for the current slot: blank gap first, then the lit digit.
  always_comb begin
    if (cnt_q < BLANK_END) begin
      sel_d = {NUM_DIGITS{1'b1}};
      seg_d = SEG_BLANK;
    end else begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = digit_seg | 8'h80;
    end
  end

  // State and registered outputs, blank on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      hold_q      <= '0;
      frame_buf_q <= 32'h0;
      owner_q     <= 1'b0;
      ack_q       <= 2'b00;
      fs_q        <= 1'b0;
      sel_q       <= {NUM_DIGITS{1'b1}};
      seg_q       <= SEG_BLANK;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      frame_buf_q <= frame_buf_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
      fs_q        <= fs_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
    end
  end

  assign ack_o         = ack_q;
  assign owner_o       = owner_q;
  assign frame_start_o = fs_q;
  assign sel_o         = sel_q;
  assign seg_o         = seg_q;

endmodule

// File: tb/tb_seg7_scan_arbiter.sv
// Frame-level bench for seg7_scan_arbiter: per-frame arbitration vectors plus a pixel
// scoreboard holding the expected sel/seg for every cycle of a frame.
module tb_seg7_scan_arbiter;

  localparam int unsigned CLK_HZ      = 80;
  localparam int unsigned SCAN_HZ     = 10;
  localparam int unsigned BLANK_CYC   = 2;
  localparam int unsigned HOLD_FRAMES = 2;
  localparam int          DIV         = 8;
  localparam int          FRAME       = 64;
  localparam int          NVEC        = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [31:0] data0_i;
  logic [31:0] data1_i;
  logic [1:0]  ack_o;
  logic        owner_o;
  logic        frame_start_o;
  logic [7:0]  sel_o;
  logic [7:0]  seg_o;

  always #5 clk = ~clk;

  seg7_scan_arbiter #(
    .CLK_HZ      (CLK_HZ),
    .SCAN_HZ     (SCAN_HZ),
    .BLANK_CYC   (BLANK_CYC),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .data0_i       (data0_i),
    .data1_i       (data1_i),
    .ack_o         (ack_o),
    .owner_o       (owner_o),
    .frame_start_o (frame_start_o),
    .sel_o         (sel_o),
    .seg_o         (seg_o)
  );

  typedef struct {
    logic [7:0] sel;
    logic [7:0] seg;
  } pix_t;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d0_mid;
    logic [31:0] d1;
    logic [1:0]  ack;
    logic        owner;
    logic [31:0] latched;
  } vec_t;

  logic [7:0] seg_ref [16];
  vec_t       vecs [NVEC];
  pix_t       sb [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [31:0] cur_buf;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered on the cycle with frame_start (or right after reset release); returns on the
  // next frame_start cycle, having compared the pins against exp_buf on every cycle.
  task automatic check_frame(input logic [31:0] exp_buf, input logic [31:0] mid_d0,
                             input bit mid_en, input string tag);
    for (int k = 0; k < FRAME; k++) begin
      pix_t p;
      int slot = k / DIV;
      int pos  = k % DIV;
      logic [3:0] nib;
      if (pos < int'(BLANK_CYC)) begin
        p.sel = 8'hFF;
        p.seg = 8'hFF;
      end else begin
        nib   = 4'((exp_buf >> (28 - 4 * slot)) & 32'hF);
        p.sel = ~(8'h01 << slot);
        p.seg = seg_ref[nib];
      end
      sb.push_back(p);
    end
    for (int k = 1; k <= FRAME; k++) begin
      pix_t e;
      @(negedge clk);
      if (mid_en && k == FRAME / 2) data0_i = mid_d0;
      e = sb.pop_front();
      cmp({tag, " sel"}, {24'h0, sel_o}, {24'h0, e.sel});
      cmp({tag, " seg"}, {24'h0, seg_o}, {24'h0, e.seg});
      cmp({tag, " frame_start"}, {31'h0, frame_start_o}, (k == FRAME) ? 32'd1 : 32'd0);
      if (k < FRAME) cmp({tag, " ack idle"}, {30'h0, ack_o}, 32'd0);
    end
  endtask

  initial begin
    seg_ref = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    //          req    d0            d0_mid        d1            ack    own   latched
    vecs[0] = '{2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_0000};
    vecs[1] = '{2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_0000};
    vecs[2] = '{2'b01, 32'h0123_4567, 32'h0123_4567, 32'hCAFE_F00D, 2'b01, 1'b0, 32'h0123_4567};
    vecs[3] = '{2'b11, 32'h0123_4567, 32'hFFFF_FFFF, 32'h89AB_CDEF, 2'b01, 1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h89AB_CDEF, 2'b10, 1'b1, 32'h89AB_CDEF};
    vecs[5] = '{2'b11, 32'h1111_1111, 32'h1111_1111, 32'h7654_3210, 2'b10, 1'b1, 32'h7654_3210};
    vecs[6] = '{2'b01, 32'h2468_ACE0, 32'h2468_ACE0, 32'h5555_5555, 2'b01, 1'b0, 32'h2468_ACE0};
    vecs[7] = '{2'b10, 32'h3333_3333, 32'h3333_3333, 32'hFEDC_BA98, 2'b10, 1'b1, 32'hFEDC_BA98};
    vecs[8] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h1357_9BDF, 2'b00, 1'b1, 32'hFEDC_BA98};
    vecs[9] = '{2'b11, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 2'b10, 1'b1, 32'hBBBB_BBBB};

    rst_n   = 1'b0;
    req_i   = 2'b00;
    data0_i = 32'h0;
    data1_i = 32'h0;
    repeat (3) @(negedge clk);
    cmp("reset sel", {24'h0, sel_o}, 32'hFF);
    cmp("reset seg", {24'h0, seg_o}, 32'hFF);
    cmp("reset ack", {30'h0, ack_o}, 32'd0);
    cmp("reset owner", {31'h0, owner_o}, 32'd0);
    cmp("reset frame_start", {31'h0, frame_start_o}, 32'd0);
    rst_n   = 1'b1;
    cur_buf = 32'h0;

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag     = $sformatf("vec%0d", i);
      req_i   = vecs[i].req;
      data0_i = vecs[i].d0;
      data1_i = vecs[i].d1;
      check_frame(cur_buf, vecs[i].d0_mid, vecs[i].d0_mid !== vecs[i].d0, tag);
      cmp({tag, " ack"}, {30'h0, ack_o}, {30'h0, vecs[i].ack});
      cmp({tag, " owner"}, {31'h0, owner_o}, {31'h0, vecs[i].owner});
      cur_buf = vecs[i].latched;
    end

    // Reset in the middle of digit 4 of a frame with owner 1.
    req_i = 2'b00;
    repeat (4 * DIV + 4) @(negedge clk);
    cmp("pre-reset sel", {24'h0, sel_o}, 32'hEF);
    cmp("pre-reset seg", {24'h0, seg_o}, {24'h0, seg_ref[cur_buf[15:12]]});
    rst_n = 1'b0;
    #1;
    cmp("async reset sel", {24'h0, sel_o}, 32'hFF);
    cmp("async reset seg", {24'h0, seg_o}, 32'hFF);
    cmp("async reset owner", {31'h0, owner_o}, 32'd0);
    cmp("async reset ack", {30'h0, ack_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(32'h0, 32'h0, 1'b0, "post-reset");
    cmp("post-reset ack", {30'h0, ack_o}, 32'd0);
    cmp("post-reset owner", {31'h0, owner_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_arbiter.md
# seg7_scan_arbiter

Scan controller and display arbiter for the board's 8-digit common-anode 7-segment display. Two client blocks each present a 32-bit hex frame. The block chooses one client per frame using round-robin with a minimum hold, and latches the chosen frame into a shadow buffer only at frame boundaries so the display never tears. It time-multiplexes the 8 digits at a programmable rate, with a blanking gap before each digit to suppress ghosting. It sits between the client logic and the top-level `sel`/`seg` pins.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000 — input clock frequency.
- `SCAN_HZ`, 1000 — digit rate. `DIV = CLK_HZ/SCAN_HZ` clock cycles per digit.
- `BLANK_CYC`, 8 — cycles at the start of each digit slot with all digits off. Requirement: `DIV >= BLANK_CYC+2`.
- `HOLD_FRAMES`, 16 — minimum frames a grant persists while another client requests.

Ports:
- `clk`, in, 1 — clock.
- `rst_n`, in, 1 — reset, asynchronous, active-low.
- `req_i`, in, 2 — per-client display request, level.
- `data0_i`, in, 32 — client 0 frame. `[31:28]` is the leftmost digit (digit 0).
- `data1_i`, in, 32 — client 1 frame.
- `ack_o`, out, 2 — one-cycle pulse: that client's data was latched into the buffer.
- `owner_o`, out, 1 — current grant holder.
- `frame_start_o`, out, 1 — one-cycle pulse when digit index wraps to 0.
- `sel_o`, out, 8 — digit enables, active-low, one-hot-zero. Bit `i` drives digit `i`.
- `seg_o`, out, 8 — segments, active-low. Bit 7 is dp and is always 1.

## Operation
- **Prescaler:**
  - `cnt` counts 0..DIV-1 and wraps to 0.
  - `tick` = (`cnt == DIV-1`).
- **Digit index:**
  - `idx` is 3 bits and advances on `tick`, wrapping 7→0.
  - A wrap is a frame boundary: `frame_start_o` pulses in the cycle `idx` becomes 0.
- **Slot shape:**
  - While `cnt < BLANK_CYC`: `sel_o = 8'hFF` and `seg_o = 8'hFF`.
  - Otherwise: `sel_o = ~(8'b1 << idx)` and `seg_o = decode(buf[31-4*idx -: 4])`.
- **Decode table:**
  - 0–7: `C0 F9 A4 B0 99 92 82 F8`.
  - 8–F: `80 90 88 83 C6 A1 86 8E`.
- **Arbitration**, evaluated only at a frame boundary (the tick with `idx == 7`). `other = ~owner`. Checked in order; first match applies:
  - `req[other]` && (`!req[owner]` || `hold >= HOLD_FRAMES`): owner becomes `other`, `hold` clears to 0, latch `data_other`, pulse `ack[other]`.
  - `req[owner]`: keep owner, latch `data_owner`, pulse `ack[owner]`, `hold` increments, saturating at `HOLD_FRAMES`.
  - Neither requesting: buffer frozen, no ack, `hold` unchanged.
- Client data is not sampled at any other time. Mid-frame changes on `data*_i` are ignored.

## Timing
- `sel_o` and `seg_o` are registered: they reflect the `cnt`/`idx` of the previous cycle (1-cycle latency).
- `buf`, `owner_o`, `ack_o` and `frame_start_o` update on the same clock edge as the boundary `tick`.
- The first digit 0 using the new buffer becomes visible on the pins at `BLANK_CYC+1` cycles after the boundary edge.
- Reset values (asynchronous, immediate, including mid-frame):
  - `sel_o = 8'hFF`, `seg_o = 8'hFF` (blank).
  - `ack_o = 0`, `owner_o = 0`, `frame_start_o = 0`.
  - `cnt = 0`, `idx = 0`, `hold = 0`, `buf = 0`.
- After reset release, digit 0 shows "0" until the first boundary latches client data.
- Simultaneous cases:
  - Both requesting, hold not expired: no switch.
  - Owner drops `req` exactly at the boundary while other requests: switch.
- `ack_o` is never 2'b11.

## Structure
- Shared package `seg7_pkg`:
  - `NUM_DIGITS = 8`.
  - `SEG_BLANK = 8'hFF`.
  - The 16-entry hex-to-segment constant table.
- One combinational sub-module, `seg7_hex_decode` (4-bit in, 8-bit out). Reused by other display blocks.
- Prescaler, scan counter, arbiter and buffer stay in this module.

## Test plan
All scenarios use `CLK_HZ=80`, `SCAN_HZ=10`, `BLANK_CYC=2`, `HOLD_FRAMES=2`, giving `DIV=8` and 64 cycles per frame.

1. **Reset and idle.** Reset, `req=00`, run 2 frames → `sel_o` cycles FE..7F, each slot preceded by 2 blank cycles; `seg_o=C0` on every lit digit; no `ack_o`.
2. **Single client.** `req=01`, `data0=32'h0123_4567` → at the first boundary `ack=01`; next frame shows `C0 F9 A4 B0 99 92 82 F8` on digits 0..7.
3. **No tearing.** Change `data0` to `32'hFFFF_FFFF` mid-frame → the current frame is unchanged; the next frame shows `8E` on all digits.
4. **Hold and switch.** `req=11` with owner 0 → owner stays 0 until `hold` reaches 2, then switches to 1 at the next boundary with `ack=10`.
5. **Owner release.** Owner 1 drops `req` while `req0=1` → switch to 0 at the next boundary regardless of `hold`.
6. **Mid-frame reset.** Assert `rst_n=0` at `idx=4` → `sel_o=FF` and `seg_o=FF` in the same cycle; after release, `idx` restarts at 0 and `owner_o=0`.
